spi_dev_bridge: RTL and testbench
=================================

SPI_DEV_BRIDGE -- requirements
Module: spi_dev_bridge

Interface
REQ-001 SHALL have the following parameter: CMD_WR, default 8'h02, write-word command code.
REQ-002 SHALL have the following parameter: CMD_RD, default 8'h0B, read-word command code.
REQ-003 SHALL have the following parameter: DUMMY_BITS, default 8, turnaround bits between read address and read data.
REQ-004 SHALL have port clk_i: input, 1 bit, sole clock; single clock domain; SPI pins are sampled in this domain.
REQ-005 SHALL have port rst_ni: input, 1 bit, asynchronous active-low reset.
REQ-006 SHALL have port spi_sclk: input, 1 bit, SPI clock from the master, CPOL=0/CPHA=0.
REQ-007 SHALL have port spi_cs: input, 1 bit, active-low chip select.
REQ-008 SHALL have port spi_sdi0: input, 1 bit, serial data in, MSB first.
REQ-009 SHALL have port spi_sdo0: output, 1 bit, serial data out, MSB first.
REQ-010 SHALL have port spi_mode: output, 2 bits, constant 2'b00 (standard single-lane).
REQ-011 SHALL have memory-side ports: mem_req_o (out, 1), mem_we_o (out, 1), mem_addr_o (out, 32), mem_wdata_o (out, 32), mem_gnt_i (in, 1), mem_rvalid_i (in, 1), mem_rdata_i (in, 32).
REQ-012 SHALL have port overflow_o: output, 1 bit, one-cycle pulse when a completed write is dropped.
REQ-013 SHALL have port rd_err_o: output, 1 bit, one-cycle pulse when read data is late.

Function
REQ-014 SHALL synchronize spi_sclk, spi_cs and spi_sdi0 through 2-flop synchronizers and detect sclk edges from the synchronized value; a legal spi_sclk period is >= 4 clk_i periods.
REQ-015 SHALL sample sdi on the detected sclk rising edge and update sdo on the detected sclk falling edge.
REQ-016 SHALL implement the FSM states IDLE, CMD (8 bits), ADDR (32 bits), WDATA (32 bits), DUMMY (DUMMY_BITS), RDATA (32 bits) and IGNORE.
REQ-017 SHALL go IDLE->CMD on the synchronized cs falling edge.
REQ-018 After CMD, SHALL go to ADDR when cmd==CMD_WR or CMD_RD, otherwise to IGNORE.
REQ-019 SHALL go ADDR->WDATA for a write; for a read, ADDR->DUMMY->RDATA.
REQ-020 SHALL go WDATA/RDATA->IGNORE after the last bit; IGNORE holds until cs rises.
REQ-021 SHALL treat any synchronized cs rise in any state as a return to IDLE; a partial frame issues no memory transaction.
REQ-022 Write: on the 32nd data bit, SHALL load {addr, data} into a one-entry buffer and assert mem_req_o=1, mem_we_o=1 on the next clk_i cycle.
REQ-023 Write: SHALL hold mem_req_o, mem_addr_o and mem_wdata_o stable until a cycle with mem_gnt_i=1, then deassert mem_req_o in the following cycle.
REQ-024 Write: SHALL, if a second write completes while the buffer is still pending, drop the new write, keep the pending one, and pulse overflow_o for one cycle.
REQ-025 Read: on the 32nd address bit, SHALL issue mem_req_o=1, mem_we_o=0 with the same hold-until-grant rule.
REQ-026 Read: SHALL capture mem_rdata_i on mem_rvalid_i.
REQ-027 Read: if rvalid has not arrived by the last DUMMY bit, SHALL shift out 32'h0 and pulse rd_err_o.
REQ-028 Read: a late rvalid for that read SHALL be discarded.
REQ-029 A read frame completed while a write is pending SHALL wait for that write's grant first (writes ordered before reads).
REQ-030 SHALL drive spi_sdo0 to 0 outside RDATA.
REQ-031 spi_mode SHALL be 2'b00 at all times.

Reset
REQ-032 On rst_ni=0, SHALL immediately set: FSM=IDLE, mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, spi_sdo0=0, overflow_o=0, rd_err_o=0, buffers and bit counter cleared, synchronizers=idle values (cs=1, sclk=0).
REQ-033 Reset mid-frame SHALL abort the frame and leave no pending request.
REQ-034 After reset release, SHALL require a fresh cs falling edge before decoding.

Structure
REQ-035 The shared package spi_dev_pkg SHALL hold the FSM state enum, CMD_WR/CMD_RD defaults and the 32-bit addr/data widths.
REQ-036 The design SHALL use one sub-module, spi_sync_edge (2-flop synchronizer plus rise/fall edge detect), instantiated for sclk and cs.

Verification
REQ-037 Write cmd 0x02, addr 0x80, data 0x00000fff -> one mem_req_o with we=1, addr 0x80, wdata 0x00000fff; gnt given immediately; no overflow_o.
REQ-038 Same write with mem_gnt_i held low 20 cycles -> req/addr/wdata stable for 20 cycles, dropped the cycle after gnt.
REQ-039 Read cmd 0x0B, addr 0x84, rvalid 3 cycles after gnt with 0xA5A5_0F0F -> after 8 dummy bits sdo0 shifts 0xA5A50F0F MSB first.
REQ-040 Read with rvalid never asserted -> sdo0 shifts 0x00000000 and rd_err_o pulses once.
REQ-041 Unknown cmd 0x55, or cs raised after 20 bits of a write -> no mem_req_o; the next valid write at 0x88 completes normally.
REQ-042 Two back-to-back writes (0x80, 0x84) with gnt held low -> only 0x80 is issued and overflow_o pulses once; rst_ni pulsed mid-ADDR -> outputs go to reset values.

Source files
------------

// File: rtl/spi_dev_pkg.sv
// Shared types and constants for the SPI device bridge.
// Frame states, default command codes and bus widths.
package spi_dev_pkg;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  localparam logic [7:0] CMD_WR_DEF = 8'h02;
  localparam logic [7:0] CMD_RD_DEF = 8'h0B;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_WDATA,
    S_DUMMY,
    S_RDATA,
    S_IGNORE
  } state_e;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wbuf_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer with rise/fall detection
// on the synchronized level.
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic [1:0] sync_q;
  logic       prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {2{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[0], d_i};
      prev_q <= sync_q[1];
    end
  end

  assign rise_o = sync_q[1] & ~prev_q;
  assign fall_o = ~sync_q[1] & prev_q;

endmodule

// File: rtl/spi_dev_bridge.sv
// SPI slave that turns single-word write/read frames
// into requests on a req/gnt/rvalid memory port.
module spi_dev_bridge
  import spi_dev_pkg::*;
#(
  parameter logic [7:0]  CMD_WR     = CMD_WR_DEF,
  parameter logic [7:0]  CMD_RD     = CMD_RD_DEF,
  parameter int unsigned DUMMY_BITS = 8
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          spi_sclk,
  input  logic          spi_cs,
  input  logic          spi_sdi0,
  output logic          spi_sdo0,
  output logic [1:0]    spi_mode,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic          mem_gnt_i,
  input  logic          mem_rvalid_i,
  input  logic [DW-1:0] mem_rdata_i,
  output logic          overflow_o,
  output logic          rd_err_o
);

  logic sclk_rise, sclk_fall;
  logic cs_rise, cs_fall;
  logic [1:0] sdi_q;

  spi_sync_edge #(.RST_VAL(1'b0)) u_sclk (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (spi_sclk),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  spi_sync_edge #(.RST_VAL(1'b1)) u_cs (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (spi_cs),
    .rise_o (cs_rise),
    .fall_o (cs_fall)
  );

  state_e        state_q;
  logic [7:0]    cnt_q, lim;
  logic [31:0]   sh_q, sh_n;
  logic [7:0]    cmd_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] tx_q;
  logic          sdo_q;
  logic [1:0]    init_q;

  wbuf_t         wbuf_q;
  logic          wpend_q, rpend_q;
  logic [AW-1:0] raddr_q;
  logic          rwait_q, rdisc_q, rvld_q;
  logic [DW-1:0] rbuf_q;
  logic          req_q, we_q;
  logic [AW-1:0] maddr_q;
  logic [DW-1:0] mwdata_q;
  logic          ovf_q, rderr_q;

  logic last, bit_ev;
  logic wr_done, wr_ok, rd_evt, rd_to;

  always_comb begin
    lim = 8'd31;
    unique case (1'b1)
      state_q == S_CMD:   lim = 8'd7;
      state_q == S_DUMMY: lim = 8'(DUMMY_BITS - 1);
      default:            lim = 8'd31;
    endcase
  end

  assign sh_n    = {sh_q[30:0], sdi_q[1]};
  assign last    = cnt_q == lim;
  assign bit_ev  = sclk_rise & ~cs_rise & last;
  assign wr_done = bit_ev & (state_q == S_WDATA);
  assign wr_ok   = wr_done & ~wpend_q;
  assign rd_evt  = bit_ev & (state_q == S_ADDR)
                 & (cmd_q == CMD_RD);
  assign rd_to   = bit_ev & (state_q == S_DUMMY)
                 & ~rvld_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sdi_q   <= '0;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      cmd_q   <= '0;
      addr_q  <= '0;
      tx_q    <= '0;
      sdo_q   <= 1'b0;
      init_q  <= '0;
    end else begin
      sdi_q <= {sdi_q[0], spi_sdi0};
      if (init_q != 2'd3) init_q <= init_q + 2'd1;
      // Falls seen while the cs chain flushes come from reset, not the master.
      if (cs_rise) begin
        state_q <= S_IDLE;
      end else if (state_q == S_IDLE) begin
        if (cs_fall && init_q == 2'd3) begin
          state_q <= S_CMD;
          cnt_q   <= '0;
        end
      end else if (sclk_rise) begin
        sh_q  <= sh_n;
        cnt_q <= last ? 8'd0 : cnt_q + 8'd1;
        if (last) begin
          unique case (state_q)
            S_CMD: begin
              cmd_q   <= sh_n[7:0];
              state_q <= (sh_n[7:0] == CMD_WR ||
                          sh_n[7:0] == CMD_RD)
                       ? S_ADDR : S_IGNORE;
            end
            S_ADDR: begin
              addr_q  <= sh_n;
              state_q <= (cmd_q == CMD_WR)
                       ? S_WDATA : S_DUMMY;
            end
            S_DUMMY: begin
              tx_q    <= rvld_q ? rbuf_q : '0;
              state_q <= S_RDATA;
            end
            S_WDATA,
            S_RDATA: state_q <= S_IGNORE;
            default: state_q <= state_q;
          endcase
        end
      end
      if (state_q == S_RDATA && sclk_fall) begin
        sdo_q <= tx_q[31];
        tx_q  <= {tx_q[30:0], 1'b0};
      end else if (state_q != S_RDATA) begin
        sdo_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wbuf_q   <= '0;
      wpend_q  <= 1'b0;
      rpend_q  <= 1'b0;
      raddr_q  <= '0;
      rwait_q  <= 1'b0;
      rdisc_q  <= 1'b0;
      rvld_q   <= 1'b0;
      rbuf_q   <= '0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      maddr_q  <= '0;
      mwdata_q <= '0;
      ovf_q    <= 1'b0;
      rderr_q  <= 1'b0;
    end else begin
      ovf_q   <= wr_done & wpend_q;
      rderr_q <= rd_to;
      if (wr_ok) begin
        wpend_q <= 1'b1;
        wbuf_q  <= '{addr: addr_q, data: sh_n};
      end
      if (req_q) begin
        if (mem_gnt_i) begin
          req_q <= 1'b0;
          if (we_q) begin
            wpend_q <= 1'b0;
          end else begin
            rpend_q <= 1'b0;
            rwait_q <= 1'b1;
          end
        end
      end else if (wpend_q || wr_ok) begin
        req_q    <= 1'b1;
        we_q     <= 1'b1;
        maddr_q  <= wpend_q ? wbuf_q.addr : addr_q;
        mwdata_q <= wpend_q ? wbuf_q.data : sh_n;
      end else if (rpend_q || rd_evt) begin
        req_q    <= 1'b1;
        we_q     <= 1'b0;
        maddr_q  <= rpend_q ? raddr_q : sh_n;
        mwdata_q <= '0;
      end
      if (rd_evt) begin
        rpend_q <= 1'b1;
        raddr_q <= sh_n;
        rvld_q  <= 1'b0;
        rdisc_q <= 1'b0;
      end
      // A read that missed its slot must not leak into the next one.
      if (rd_to) rdisc_q <= rwait_q | rpend_q;
      if (mem_rvalid_i && rwait_q) begin
        rwait_q <= 1'b0;
        rdisc_q <= 1'b0;
        if (!rdisc_q) begin
          rbuf_q <= mem_rdata_i;
          rvld_q <= 1'b1;
        end
      end
    end
  end

  assign spi_sdo0    = sdo_q & (state_q == S_RDATA);
  assign spi_mode    = 2'b00;
  assign mem_req_o   = req_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = maddr_q;
  assign mem_wdata_o = mwdata_q;
  assign overflow_o  = ovf_q;
  assign rd_err_o    = rderr_q;

endmodule

// File: tb/tb_spi_dev_bridge.sv
// Directed bench for spi_dev_bridge: write, read,
// timeout, abort, overflow and reset scenarios.
module tb_spi_dev_bridge;

  localparam int HP = 5;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        spi_sclk = 1'b0;
  logic        spi_cs = 1'b1;
  logic        spi_sdi0 = 1'b0;
  logic        spi_sdo0;
  logic [1:0]  spi_mode;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_gnt_i = 1'b0;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = 32'h0;
  logic        overflow_o, rd_err_o;

  spi_dev_bridge dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .spi_sclk     (spi_sclk),
    .spi_cs       (spi_cs),
    .spi_sdi0     (spi_sdi0),
    .spi_sdo0     (spi_sdo0),
    .spi_mode     (spi_mode),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .overflow_o   (overflow_o),
    .rd_err_o     (rd_err_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  int          gnt_wait = 0;
  int          rv_delay = 3;
  logic        rv_en = 1'b1;
  logic [31:0] rv_data = 32'h0;
  int          rv_timer = -1;
  int          txn = 0;
  int          req_len = 0;
  logic        unstable = 1'b0;
  logic        req_prev = 1'b0;
  logic [31:0] t_addr = 0, t_wdata = 0;
  logic        t_we = 1'b0;
  int          ovf_cnt = 0, rerr_cnt = 0;

  always @(negedge clk) begin
    ovf_cnt  += int'(overflow_o);
    rerr_cnt += int'(rd_err_o);
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = 32'hDEAD_BEEF;
    if (rv_timer > 0) begin
      rv_timer--;
      if (rv_timer == 0) begin
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = rv_data;
        rv_timer     = -1;
      end
    end
    if (mem_req_o) begin
      if (!req_prev) begin
        txn++;
        t_addr   = mem_addr_o;
        t_wdata  = mem_wdata_o;
        t_we     = mem_we_o;
        req_len  = 0;
        unstable = 1'b0;
      end else if (mem_addr_o != t_addr ||
                   mem_wdata_o != t_wdata ||
                   mem_we_o != t_we) begin
        unstable = 1'b1;
      end
      req_len++;
      mem_gnt_i = req_len > gnt_wait;
      if (mem_gnt_i && !mem_we_o && rv_en)
        rv_timer = rv_delay;
    end else begin
      mem_gnt_i = 1'b0;
    end
    req_prev = mem_req_o;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h",
               tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic sbit(input logic b,
                      output logic r);
    spi_sdi0 = b;
    tick(HP);
    r = spi_sdo0;
    spi_sclk = 1'b1;
    tick(HP);
    spi_sclk = 1'b0;
  endtask

  task automatic sword(input logic [31:0] v,
                       input int n);
    logic r;
    for (int i = n - 1; i >= 0; i--)
      sbit(v[i], r);
  endtask

  task automatic rword(output logic [31:0] v);
    logic r;
    v = '0;
    for (int i = 31; i >= 0; i--) begin
      sbit(1'b0, r);
      v[i] = r;
    end
  endtask

  task automatic cs_on();
    spi_cs = 1'b0;
    tick(HP);
  endtask

  task automatic cs_off();
    tick(HP);
    spi_cs = 1'b1;
    spi_sdi0 = 1'b0;
    tick(4 * HP);
  endtask

  task automatic wr_frame(input logic [31:0] a,
                          input logic [31:0] d);
    cs_on();
    sword(32'h02, 8);
    sword(a, 32);
    sword(d, 32);
    cs_off();
  endtask

  task automatic rd_frame(input logic [31:0] a,
                          output logic [31:0] d);
    cs_on();
    sword(32'h0B, 8);
    sword(a, 32);
    sword(32'h0, 8);
    rword(d);
    cs_off();
  endtask

  task automatic chk_reset(input string p);
    chk({p, "_req"},   32'(mem_req_o),   0);
    chk({p, "_we"},    32'(mem_we_o),    0);
    chk({p, "_addr"},  mem_addr_o,       0);
    chk({p, "_wdata"}, mem_wdata_o,      0);
    chk({p, "_sdo"},   32'(spi_sdo0),    0);
    chk({p, "_ovf"},   32'(overflow_o),  0);
    chk({p, "_rderr"}, 32'(rd_err_o),    0);
  endtask

  initial begin
    int base, obase, rbase;
    logic [31:0] rd;

    tick(3);
    chk_reset("rst");
    chk("mode", 32'(spi_mode), 0);
    rst_ni = 1'b1;
    tick(10);

    gnt_wait = 0;
    base = txn; obase = ovf_cnt;
    wr_frame(32'h80, 32'h0000_0fff);
    tick(10);
    chk("w1_txn",   32'(txn - base), 1);
    chk("w1_we",    32'(t_we), 1);
    chk("w1_addr",  t_addr, 32'h80);
    chk("w1_wdata", t_wdata, 32'h0000_0fff);
    chk("w1_len",   32'(req_len), 1);
    chk("w1_ovf",   32'(ovf_cnt - obase), 0);

    gnt_wait = 20;
    base = txn;
    wr_frame(32'h80, 32'h0000_0fff);
    tick(30);
    chk("w2_txn",    32'(txn - base), 1);
    chk("w2_stable", 32'(unstable), 0);
    chk("w2_len",    32'(req_len), 21);
    chk("w2_wdata",  t_wdata, 32'h0000_0fff);

    gnt_wait = 0; rv_en = 1'b1; rv_delay = 3;
    rv_data = 32'hA5A5_0F0F;
    base = txn; rbase = rerr_cnt;
    rd_frame(32'h84, rd);
    chk("r1_data",  rd, 32'hA5A5_0F0F);
    chk("r1_we",    32'(t_we), 0);
    chk("r1_addr",  t_addr, 32'h84);
    chk("r1_rderr", 32'(rerr_cnt - rbase), 0);

    rv_en = 1'b0;
    rbase = rerr_cnt;
    rd_frame(32'h90, rd);
    chk("r2_data",  rd, 32'h0);
    chk("r2_rderr", 32'(rerr_cnt - rbase), 1);
    rv_en = 1'b1;

    base = txn;
    cs_on();
    sword(32'h55, 8);
    sword(32'h80, 32);
    sword(32'h1234, 32);
    cs_off();
    chk("bad_cmd_txn", 32'(txn - base), 0);
    cs_on();
    sword(32'h02, 8);
    sword(32'h0, 12);
    cs_off();
    tick(20);
    chk("trunc_txn", 32'(txn - base), 0);
    wr_frame(32'h88, 32'h1234_5678);
    tick(10);
    chk("w3_txn",   32'(txn - base), 1);
    chk("w3_addr",  t_addr, 32'h88);
    chk("w3_wdata", t_wdata, 32'h1234_5678);

    gnt_wait = 100000;
    base = txn; obase = ovf_cnt;
    wr_frame(32'h80, 32'h1111_1111);
    wr_frame(32'h84, 32'h2222_2222);
    tick(10);
    chk("ov_txn",   32'(txn - base), 1);
    chk("ov_addr",  t_addr, 32'h80);
    chk("ov_wdata", t_wdata, 32'h1111_1111);
    chk("ov_pulse", 32'(ovf_cnt - obase), 1);
    gnt_wait = 0;
    tick(40);
    chk("ov_drop",  32'(txn - base), 1);
    chk("ov_idle",  32'(mem_req_o), 0);

    gnt_wait = 100000;
    base = txn;
    wr_frame(32'h80, 32'h3333_3333);
    chk("pre_rst_req", 32'(mem_req_o), 1);
    cs_on();
    sword(32'h02, 8);
    sword(32'h0, 10);
    rst_ni = 1'b0;
    #1;
    chk_reset("mid");
    tick(2);
    spi_cs = 1'b1;
    spi_sclk = 1'b0;
    rst_ni = 1'b1;
    tick(20);
    gnt_wait = 0;
    tick(40);
    chk("post_rst_txn", 32'(txn - base), 1);
    wr_frame(32'h8C, 32'hCAFE_F00D);
    tick(10);
    chk("w4_txn",   32'(txn - base), 2);
    chk("w4_addr",  t_addr, 32'h8C);
    chk("w4_wdata", t_wdata, 32'hCAFE_F00D);
    chk("mode_end", 32'(spi_mode), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
